// File: rtl/mux_21_arbiter.sv
// Round-robin arbiter for two requesters sharing one 2:1 mux path.
// Drives a one-hot grant and the mux select, and registers the routed input as mux_out.
module mux_21_arbiter #(
    parameter int WIDTH    = 1,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [2*WIDTH-1:0] mux_in,
    output logic [1:0]         gnt,
    output logic               sel,
    output logic [WIDTH-1:0]   mux_out,
    output logic               out_valid
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic               last_q, last_d;
    logic [WIDTH-1:0]   mux_out_q, mux_out_d;
    logic               out_valid_q, out_valid_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            last_q      <= 1'b1;
            mux_out_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            last_q      <= last_d;
            mux_out_q   <= mux_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;

        case (state_q)
            IDLE: begin
                case (req)
                    2'b01:   state_d = GRANT0;
                    2'b10:   state_d = GRANT1;
                    2'b11:   state_d = last_q ? GRANT0 : GRANT1;
                    default: state_d = IDLE;
                endcase
            end
            GRANT0: begin
                // Hand over directly so the path never idles while the other side waits.
                if (!req[0]) begin
                    state_d = req[1] ? GRANT1 : IDLE;
                end else if (req[1] && (hold_cnt_q == HOLD_LAST)) begin
                    state_d = GRANT1;
                end
            end
            GRANT1: begin
                if (!req[1]) begin
                    state_d = req[0] ? GRANT0 : IDLE;
                end else if (req[0] && (hold_cnt_q == HOLD_LAST)) begin
                    state_d = GRANT0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            hold_cnt_d = '0;
            if (state_d == GRANT0) begin
                last_d = 1'b0;
            end else if (state_d == GRANT1) begin
                last_d = 1'b1;
            end
        end else if ((state_q != IDLE) && (hold_cnt_q != HOLD_LAST)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // Data path: capture whichever input the current grant routes; hold it while idle.
    always_comb begin
        mux_out_d   = mux_out_q;
        out_valid_d = (state_q != IDLE);
        if (state_q == GRANT0) begin
            mux_out_d = mux_in[WIDTH-1:0];
        end else if (state_q == GRANT1) begin
            mux_out_d = mux_in[2*WIDTH-1:WIDTH];
        end
    end

    assign gnt       = {state_q == GRANT1, state_q == GRANT0};
    assign sel       = (state_q == GRANT1);
    assign mux_out   = mux_out_q;
    assign out_valid = out_valid_q;

endmodule
